// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM channel.
// The state encoding and output-mux selects are used by pwm_channel.
package pwm_pkg;

  typedef enum logic [1:0] {
    PWM_IDLE = 2'd0,
    PWM_ARM  = 2'd1,
    PWM_RUN  = 2'd2,
    PWM_DONE = 2'd3
  } pwm_state_t;

  // Output mux select: drive the polarity-defined idle level, or the compare result.
  localparam logic PWM_IDLE_LVL_SEL = 1'b0;
  localparam logic PWM_CMP_SEL      = 1'b1;

endpackage

// File: rtl/pwm_channel.sv
// Single PWM channel: compares the shared period counter against a double-buffered duty.
// Duty changes take effect only at period boundaries; supports one-shot and a sticky irq.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int COUNTER_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [COUNTER_WIDTH-1:0] cnt_val,
  input  logic                     cnt_top_pulse,
  input  logic                     ctrl_we,
  input  logic                     ctrl_en,
  input  logic                     ctrl_pol,
  input  logic                     ctrl_oneshot,
  input  logic                     duty_we,
  input  logic [COUNTER_WIDTH:0]   duty_in,
  input  logic                     irq_clr,
  output logic                     pwm_out,
  output logic                     irq,
  output logic                     busy
);

  localparam int DW = COUNTER_WIDTH + 1;

  pwm_state_t    state_r;
  pwm_state_t    state_nxt_s;
  logic          ctrl_en_r;
  logic          ctrl_pol_r;
  logic          ctrl_oneshot_r;
  logic [DW-1:0] duty_pend_r;
  logic          pend_vld_r;
  logic [DW-1:0] duty_act_r;
  logic          irq_r;
  logic          pwm_r;
  logic          busy_r;

  logic          disable_s;
  logic          load_s;
  logic          irq_set_s;
  logic          pol_s;
  logic          out_sel_s;
  logic          cmp_active_s;
  logic          pwm_nxt_s;
  logic          busy_nxt_s;
  logic [DW-1:0] cnt_ext_s;

  assign cnt_ext_s = {1'b0, cnt_val};
  assign disable_s = ctrl_we & ~ctrl_en;

  // Next-state logic; a disabling control write overrides every state.
  always_comb begin
    state_nxt_s = state_r;
    if (disable_s) begin
      state_nxt_s = PWM_IDLE;
    end else begin
      case (state_r)
        PWM_IDLE: begin
          if (ctrl_we) state_nxt_s = PWM_ARM;
          else         state_nxt_s = PWM_IDLE;
        end
        PWM_ARM: begin
          if (cnt_top_pulse) state_nxt_s = PWM_RUN;
          else               state_nxt_s = PWM_ARM;
        end
        PWM_RUN: begin
          if (cnt_top_pulse && ctrl_oneshot_r) state_nxt_s = PWM_DONE;
          else                                 state_nxt_s = PWM_RUN;
        end
        PWM_DONE: begin
          if (ctrl_we) state_nxt_s = PWM_ARM;
          else         state_nxt_s = PWM_DONE;
        end
        default: state_nxt_s = PWM_IDLE;
      endcase
    end
  end

  // Boundary load, irq set and output-mux selection.
  always_comb begin
    load_s       = 1'b0;
    irq_set_s    = 1'b0;
    out_sel_s    = PWM_IDLE_LVL_SEL;
    pol_s        = ctrl_pol_r;
    cmp_active_s = (cnt_ext_s < duty_act_r);
    pwm_nxt_s    = ctrl_pol_r;
    busy_nxt_s   = 1'b0;

    if (cnt_top_pulse) begin
      load_s    = (state_r == PWM_ARM) | ((state_r == PWM_RUN) & pend_vld_r);
      irq_set_s = (state_r == PWM_RUN);
    end else begin
      load_s    = 1'b0;
      irq_set_s = 1'b0;
    end

    // A control write changes the level in the very next output sample.
    if (ctrl_we) pol_s = ctrl_pol;
    else         pol_s = ctrl_pol_r;

    if ((state_r == PWM_RUN) && !disable_s) out_sel_s = PWM_CMP_SEL;
    else                                    out_sel_s = PWM_IDLE_LVL_SEL;

    case (out_sel_s)
      PWM_CMP_SEL: pwm_nxt_s = cmp_active_s ^ pol_s;
      default:     pwm_nxt_s = pol_s;
    endcase

    busy_nxt_s = (state_nxt_s == PWM_ARM) | (state_nxt_s == PWM_RUN);
  end

  // State and control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= PWM_IDLE;
      ctrl_en_r      <= 1'b0;
      ctrl_pol_r     <= 1'b0;
      ctrl_oneshot_r <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= busy_nxt_s;
      if (ctrl_we) begin
        ctrl_en_r      <= ctrl_en;
        ctrl_pol_r     <= ctrl_pol;
        ctrl_oneshot_r <= ctrl_oneshot;
      end
    end
  end

  // Duty double buffer and sticky interrupt; a same-cycle write stays pending past the boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_pend_r <= {DW{1'b0}};
      pend_vld_r  <= 1'b0;
      duty_act_r  <= {DW{1'b0}};
      irq_r       <= 1'b0;
    end else begin
      if (load_s) duty_act_r <= duty_pend_r;
      if (duty_we) begin
        duty_pend_r <= duty_in;
        pend_vld_r  <= 1'b1;
      end else if (load_s) begin
        pend_vld_r  <= 1'b0;
      end
      if (irq_set_s)    irq_r <= 1'b1;
      else if (irq_clr) irq_r <= 1'b0;
    end
  end

  // Registered PWM pin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_r <= 1'b0;
    end else begin
      pwm_r <= pwm_nxt_s;
    end
  end

  assign pwm_out = pwm_r;
  assign irq     = irq_r;
  assign busy    = busy_r;

endmodule
